// File: rtl/draw_sequencer.sv
// rtl/draw_sequencer.sv - in-order draw command scheduler sharing one VGA write port between three engines
module draw_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            CLOCK_50,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [1:0]                      cmd_op,
    input  logic [2:0]                      cmd_colour,
    input  logic [7:0]                      cmd_cx,
    input  logic [6:0]                      cmd_cy,
    input  logic [7:0]                      cmd_r,
    output logic [$clog2(FIFO_DEPTH):0]     cmd_count,
    output logic                            busy,
    output logic                            bad_cmd,
    output logic [2:0]                      eng_start,
    output logic [2:0]                      eng_colour,
    output logic [7:0]                      eng_cx,
    output logic [6:0]                      eng_cy,
    output logic [7:0]                      eng_r,
    input  logic [2:0]                      eng_done,
    input  logic [23:0]                     eng_vga_x,
    input  logic [20:0]                     eng_vga_y,
    input  logic [8:0]                      eng_vga_colour,
    input  logic [2:0]                      eng_vga_plot,
    output logic [7:0]                      vga_x,
    output logic [6:0]                      vga_y,
    output logic [2:0]                      vga_colour,
    output logic                            vga_plot
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam int EW = 28;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic [EW-1:0] head;
    logic [1:0]    head_op;
    logic [2:0]    head_colour;
    logic [7:0]    head_cx;
    logic [6:0]    head_cy;
    logic [7:0]    head_r;

    logic [1:0]    cur_op;
    logic [2:0]    cur_colour;
    logic [7:0]    cur_cx;
    logic [6:0]    cur_cy;
    logic [7:0]    cur_r;

    logic          sel_done;
    logic [7:0]    sel_x;
    logic [6:0]    sel_y;
    logic [2:0]    sel_colour;
    logic          sel_plot;

    function automatic logic [2:0] op_onehot(input logic [1:0] op);
        case (op)
            2'd0:    op_onehot = 3'b001;
            2'd1:    op_onehot = 3'b010;
            2'd2:    op_onehot = 3'b100;
            default: op_onehot = 3'b000;
        endcase
    endfunction

    // Ready depends only on occupancy, so a full FIFO refuses even when a pop happens the same cycle
    assign cmd_ready = (count < DEPTH_C);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign cmd_count = count;
    assign busy      = (count != '0) || (state != IDLE);

    assign head        = mem[rd_ptr];
    assign head_op     = head[27:26];
    assign head_colour = head[25:23];
    assign head_cx     = head[22:15];
    assign head_cy     = head[14:8];
    assign head_r      = head[7:0];

    assign eng_colour = cur_colour;
    assign eng_cx     = cur_cx;
    assign eng_cy     = cur_cy;
    assign eng_r      = cur_r;

    // Command storage; contents need no reset because occupancy gates every read
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_colour, cmd_cx, cmd_cy, cmd_r};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Select the current engine's done and pixel lanes; the reserved op selects nothing
    always_comb begin
        sel_done   = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        sel_plot   = 1'b0;
        case (cur_op)
            2'd0: begin
                sel_done   = eng_done[0];
                sel_x      = eng_vga_x[7:0];
                sel_y      = eng_vga_y[6:0];
                sel_colour = eng_vga_colour[2:0];
                sel_plot   = eng_vga_plot[0];
            end
            2'd1: begin
                sel_done   = eng_done[1];
                sel_x      = eng_vga_x[15:8];
                sel_y      = eng_vga_y[13:7];
                sel_colour = eng_vga_colour[5:3];
                sel_plot   = eng_vga_plot[1];
            end
            2'd2: begin
                sel_done   = eng_done[2];
                sel_x      = eng_vga_x[23:16];
                sel_y      = eng_vga_y[20:14];
                sel_colour = eng_vga_colour[8:6];
                sel_plot   = eng_vga_plot[2];
            end
            default: begin
                sel_done   = 1'b0;
            end
        endcase
    end

    // Adapter port is driven by the selected engine only while it is running, otherwise held at zero
    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        if (state == RUN) begin
            vga_x      = sel_x;
            vga_y      = sel_y;
            vga_colour = sel_colour;
            vga_plot   = sel_plot;
        end
    end

    // Sequencing FSM: pop in IDLE, hold start until done, then wait for done to clear before the next pop
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state      <= IDLE;
            eng_start  <= '0;
            bad_cmd    <= 1'b0;
            cur_op     <= '0;
            cur_colour <= '0;
            cur_cx     <= '0;
            cur_cy     <= '0;
            cur_r      <= '0;
        end else begin
            bad_cmd <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_op     <= head_op;
                        cur_colour <= head_colour;
                        cur_cx     <= head_cx;
                        cur_cy     <= head_cy;
                        cur_r      <= head_r;
                        if (head_op == 2'd3) begin
                            bad_cmd <= 1'b1;
                        end else begin
                            state     <= RUN;
                            eng_start <= op_onehot(head_op);
                        end
                    end
                end
                RUN: begin
                    if (sel_done) begin
                        state     <= RELEASE;
                        eng_start <= '0;
                    end
                end
                RELEASE: begin
                    eng_start <= '0;
                    if (!sel_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    eng_start <= '0;
                end
            endcase
        end
    end

endmodule
